// File: rtl/slave_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// slave_write_arbiter_if
// Request/grant bundle between the per-master decoders, the slave-side
// handshake detectors, and one slave_write_arbiter instance.
//   req        : per-master "AWVALID and decoded to this slave"
//   aw_hs      : AW handshake seen on the currently granted path
//   b_hs       : B handshake seen on the currently granted path
//   grant      : one-hot owner of the slave path (zero when free)
//   grant_idx  : binary index of the owner (zero when free)
//   locked     : high while a grant is active
// The slave modport is the arbiter's view. The master modport is the view of
// whoever drives the requests and handshakes.
// -----------------------------------------------------------------------------
interface slave_write_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0] req;
    logic                   aw_hs;
    logic                   b_hs;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   locked;

    modport slave (
        input  req, aw_hs, b_hs,
        output grant, grant_idx, locked
    );

    modport master (
        output req, aw_hs, b_hs,
        input  grant, grant_idx, locked
    );
endinterface

// File: rtl/slave_write_arbiter.sv
// -----------------------------------------------------------------------------
// slave_write_arbiter
// Round-robin write-channel arbiter for one slave port of the AXI4 crossbar.
// It picks one requesting master while free. It then locks the AW/W/B path
// to that master until the B handshake completes.
//   ACLK     : clock, rising edge
//   ARESETn  : asynchronous active-low reset
//   bus      : slave_write_arbiter_if.slave (req, aw_hs, b_hs in;
//              grant, grant_idx, locked out)
// All outputs are registered.
// -----------------------------------------------------------------------------
module slave_write_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    slave_write_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state,    state_nxt;
    logic [IDX_W-1:0]       ptr,      ptr_nxt;
    logic [NUM_MASTERS-1:0] grant_q,  grant_nxt;
    logic [IDX_W-1:0]       idx_q,    idx_nxt;
    logic                   locked_q, locked_nxt;

    logic                   win_vld;
    logic [IDX_W-1:0]       win_idx;

    // Round-robin pick. Scan offsets from the highest to the lowest. The
    // last hit is then the master closest to ptr going upward, with wrap.
    always_comb begin : rr_pick
        int pos;
        win_vld = 1'b0;
        win_idx = '0;
        pos     = 0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            pos = (int'(ptr) + i) % NUM_MASTERS;
            if (bus.req[pos]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(pos);
            end
        end
    end

    // Next-state logic. Every register holds its value by default. The
    // pointer moves only when a transaction completes, so a master that
    // waits keeps its place in the rotation while another one is served.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        grant_nxt  = grant_q;
        idx_nxt    = idx_q;
        locked_nxt = locked_q;
        unique case (state)
            IDLE: begin
                if (win_vld) begin
                    grant_nxt  = NUM_MASTERS'(1) << win_idx;
                    idx_nxt    = win_idx;
                    locked_nxt = 1'b1;
                    state_nxt  = ADDR;
                end
            end
            ADDR: begin
                if (bus.aw_hs) state_nxt = RESP;
            end
            RESP: begin
                if (bus.b_hs) begin
                    state_nxt  = IDLE;
                    grant_nxt  = '0;
                    idx_nxt    = '0;
                    locked_nxt = 1'b0;
                    ptr_nxt    = IDX_W'((int'(idx_q) + 1) % NUM_MASTERS);
                end
            end
            default: begin
                state_nxt  = IDLE;
                grant_nxt  = '0;
                idx_nxt    = '0;
                locked_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_q  <= '0;
            idx_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            grant_q  <= grant_nxt;
            idx_q    <= idx_nxt;
            locked_q <= locked_nxt;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_idx = idx_q;
    assign bus.locked    = locked_q;

endmodule
